uge_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one W-bit unsigned subtract-with-borrow comparator (A + ~B + 1, carry-out = A >= B) among N requesters. Each requester presents an operand pair and holds REQ. The block grants one requester at a time, registers its operands, computes the result on the shared datapath, and returns GE/DIFF with a one-cycle ACK to that requester. It sits between several control clients (counters, threshold checkers) and a single mantle comparator on the iCE40 fabric.

---
 rtl/uge_share_arbiter.sv | 60 ++++++
 tb/tb_uge_share_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uge_share_arbiter.sv
// uge_share_arbiter: round-robin sharing of one subtract-with-borrow comparator among N requesters
module uge_share_arbiter #(
   parameter int N  = 4,
   parameter int W  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic           CLK,
   input  logic           RESETN,
   input  logic [N-1:0]   REQ,
   input  logic [N*W-1:0] A,
   input  logic [N*W-1:0] B,
   output logic [N-1:0]   ACK,
   output logic           GE,
   output logic [W-1:0]   DIFF,
   output logic [IW-1:0]  GNT_ID,
   output logic           BUSY
);
   typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_t;
   state_t        state, state_nxt;
   logic [IW-1:0] last, win;
   logic [W-1:0]  opa, opb;
   logic [W:0]    sum;
   assign sum  = {1'b0, opa} + {1'b0, ~opb} + {{W{1'b0}}, 1'b1};
   assign ACK  = (state == RESPOND) ? N'(1) << GNT_ID : '0;
   assign BUSY = state != IDLE;
   // first requester after the last one served, scanning downward so the nearest wins
   always_comb begin
      win = last;
      for (int k = N; k >= 1; k--)
         if (REQ[IW'((int'(last) + k) % N)]) win = IW'((int'(last) + k) % N);
   end
   // three-step sequence: grant, compute, respond
   always_comb begin
      state_nxt = (state == IDLE) ? (|REQ ? COMPUTE : IDLE) : (state == COMPUTE) ? RESPOND : IDLE;
   end
   // state register; reset aborts any transaction in flight
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) state <= IDLE;
      else state <= state_nxt;
   end
   // operand capture at grant, result capture after compute, pointer update after respond
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         GNT_ID <= '0;
         opa    <= '0;
         opb    <= '0;
         GE     <= 1'b0;
         DIFF   <= '0;
         last   <= IW'(N - 1);
      end else begin
         if (state == IDLE && |REQ) begin
            GNT_ID <= win;
            opa    <= A[win*W +: W];
            opb    <= B[win*W +: W];
         end
         if (state == COMPUTE) {GE, DIFF} <= sum;
         if (state == RESPOND) last <= GNT_ID;
      end
   end
endmodule

// File: tb/tb_uge_share_arbiter.sv
// tb_uge_share_arbiter: transaction-level model check of two arbiter configurations plus directed literals
module tb_uge_share_arbiter;
   logic        CLK = 1'b0;
   logic        RESETN = 1'b1;
   logic [3:0]  req4 = '0;
   logic [15:0] a4 = '0, b4 = '0;
   logic [3:0]  ack4, diff4;
   logic        ge4, busy4;
   logic [1:0]  gnt4;
   logic [2:0]  req3 = '0;
   logic [23:0] a3 = '0, b3 = '0;
   logic [2:0]  ack3;
   logic [7:0]  diff3;
   logic        ge3, busy3;
   logic [1:0]  gnt3;
   int n_cmp = 0, n_bad = 0;
   int m4_ph, m4_ptr, m4_gnt, m4_ge, m4_diff, m4_pge, m4_pdiff, w4;
   int m3_ph, m3_ptr, m3_gnt, m3_ge, m3_diff, m3_pge, m3_pdiff, w3;

   always #5 CLK = ~CLK;

   uge_share_arbiter #(.N(4), .W(4)) dut4 (
      .CLK(CLK), .RESETN(RESETN), .REQ(req4), .A(a4), .B(b4),
      .ACK(ack4), .GE(ge4), .DIFF(diff4), .GNT_ID(gnt4), .BUSY(busy4));
   uge_share_arbiter #(.N(3), .W(8)) dut3 (
      .CLK(CLK), .RESETN(RESETN), .REQ(req3), .A(a3), .B(b3),
      .ACK(ack3), .GE(ge3), .DIFF(diff3), .GNT_ID(gnt3), .BUSY(busy3));

   function automatic int pick(input int req, input int ptr, input int n);
      for (int k = 1; k <= n; k++) if (req[(ptr + k) % n]) return (ptr + k) % n;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   always_comb w4 = pick(int'(req4), m4_ptr, 4);
   always_comb w3 = pick(int'(req3), m3_ptr, 3);

   // transaction model: result is known at grant, published one cycle later, acknowledged the next
   always @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         m4_ph <= 0; m4_ptr <= 3; m4_gnt <= 0; m4_ge <= 0; m4_diff <= 0;
      end else if (m4_ph == 0) begin
         if (w4 >= 0) begin
            m4_gnt   <= w4;
            m4_pge   <= int'(a4[w4*4 +: 4] >= b4[w4*4 +: 4]);
            m4_pdiff <= (int'(a4[w4*4 +: 4]) - int'(b4[w4*4 +: 4])) & 15;
            m4_ph    <= 1;
         end
      end else if (m4_ph == 1) begin
         m4_ge <= m4_pge; m4_diff <= m4_pdiff; m4_ph <= 2;
      end else begin
         m4_ptr <= m4_gnt; m4_ph <= 0;
      end
   end

   always @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         m3_ph <= 0; m3_ptr <= 2; m3_gnt <= 0; m3_ge <= 0; m3_diff <= 0;
      end else if (m3_ph == 0) begin
         if (w3 >= 0) begin
            m3_gnt   <= w3;
            m3_pge   <= int'(a3[w3*8 +: 8] >= b3[w3*8 +: 8]);
            m3_pdiff <= (int'(a3[w3*8 +: 8]) - int'(b3[w3*8 +: 8])) & 255;
            m3_ph    <= 1;
         end
      end else if (m3_ph == 1) begin
         m3_ge <= m3_pge; m3_diff <= m3_pdiff; m3_ph <= 2;
      end else begin
         m3_ptr <= m3_gnt; m3_ph <= 0;
      end
   end

   // every cycle, both instances against the model
   always @(negedge CLK) begin
      chk("m4_ack", 32'(ack4), (m4_ph == 2) ? (1 << m4_gnt) : 0);
      chk("m4_busy", 32'(busy4), 32'(m4_ph != 0));
      chk("m4_ge", 32'(ge4), m4_ge);
      chk("m4_diff", 32'(diff4), m4_diff);
      chk("m4_gnt", 32'(gnt4), m4_gnt);
      chk("m3_ack", 32'(ack3), (m3_ph == 2) ? (1 << m3_gnt) : 0);
      chk("m3_busy", 32'(busy3), 32'(m3_ph != 0));
      chk("m3_ge", 32'(ge3), m3_ge);
      chk("m3_diff", 32'(diff3), m3_diff);
      chk("m3_gnt", 32'(gnt3), m3_gnt);
   end

   int av[4] = '{3, 15, 0, 15};
   int bv[4] = '{7, 15, 15, 0};
   int gv[4] = '{0, 1, 0, 1};
   int dv[4] = '{12, 0, 1, 15};

   initial begin
      #1 RESETN = 1'b0;
      #1;
      chk("rst_ack", 32'(ack4), 0);
      chk("rst_busy", 32'(busy4), 0);
      chk("rst_gnt", 32'(gnt4), 0);
      tick(2);
      RESETN = 1'b1;
      // single request and its latency
      a4[3:0] = 4'd9; b4[3:0] = 4'd5; req4 = 4'b0001;
      tick(1);
      chk("t1_busy_c", 32'(busy4), 1);
      chk("t1_noack", 32'(ack4), 0);
      tick(1);
      chk("t1_ack", 32'(ack4), 1);
      chk("t1_ge", 32'(ge4), 1);
      chk("t1_diff", 32'(diff4), 4);
      chk("t1_gnt", 32'(gnt4), 0);
      chk("t1_busy_r", 32'(busy4), 1);
      req4 = '0;
      tick(1);
      chk("t1_idle", 32'(busy4), 0);
      // arithmetic corners on requester 2
      for (int i = 0; i < 4; i++) begin
         a4[11:8] = 4'(av[i]); b4[11:8] = 4'(bv[i]); req4 = 4'b0100;
         tick(2);
         chk("t2_ack", 32'(ack4), 4);
         chk("t2_ge", 32'(ge4), gv[i]);
         chk("t2_diff", 32'(diff4), dv[i]);
         chk("t2_gnt", 32'(gnt4), 2);
         req4 = '0;
         tick(1);
      end
      // fairness from a fresh pointer with all requests held
      RESETN = 1'b0;
      tick(1);
      RESETN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a4[i*4 +: 4] = 4'(i + 8); b4[i*4 +: 4] = 4'(i);
      end
      req4 = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         int c;
         c = 0;
         do begin
            tick(1);
            c++;
         end while (ack4 == 0 && c < 8);
         chk("t3_gap", c, (j == 0) ? 2 : 3);
         chk("t3_ack", 32'(ack4), 1 << (j % 4));
         chk("t3_ge", 32'(ge4), 1);
         chk("t3_diff", 32'(diff4), 8);
      end
      req4 = '0;
      tick(1);
      // operands latched at grant; a request withdrawn while busy is never served
      a4[7:4] = 4'd6; b4[7:4] = 4'd2; req4 = 4'b0010;
      tick(1);
      chk("t4_gnt", 32'(gnt4), 1);
      a4[7:4] = 4'd1; req4 = 4'b1000;
      tick(1);
      chk("t4_ack", 32'(ack4), 2);
      chk("t4_ge", 32'(ge4), 1);
      chk("t4_diff", 32'(diff4), 4);
      req4 = '0;
      tick(3);
      chk("t4_no_ack3", 32'(ack4), 0);
      chk("t4_idle", 32'(busy4), 0);
      // asynchronous reset in the middle of a transaction
      a4[3:0] = 4'd5; b4[3:0] = 4'd1; req4 = 4'b0001;
      tick(1);
      chk("t5_busy_pre", 32'(busy4), 1);
      RESETN = 1'b0;
      #1;
      chk("t5_ack", 32'(ack4), 0);
      chk("t5_busy", 32'(busy4), 0);
      chk("t5_ge", 32'(ge4), 0);
      chk("t5_diff", 32'(diff4), 0);
      chk("t5_gnt", 32'(gnt4), 0);
      tick(1);
      RESETN = 1'b1;
      a4[15:12] = 4'd2; b4[15:12] = 4'd1; req4 = 4'b1001;
      tick(2);
      chk("t5_first", 32'(ack4), 1);
      req4 = 4'b1000;
      tick(3);
      chk("t5_second", 32'(ack4), 8);
      req4 = '0;
      tick(1);
      // narrow-N, wide-W instance
      a3[15:8] = 8'd200; b3[15:8] = 8'd100; req3 = 3'b010;
      tick(2);
      chk("t6_ack", 32'(ack3), 2);
      chk("t6_ge", 32'(ge3), 1);
      chk("t6_diff", 32'(diff3), 100);
      req3 = '0;
      tick(1);
      a3[15:8] = 8'd100; b3[15:8] = 8'd200; req3 = 3'b010;
      tick(2);
      chk("t6_ge_lt", 32'(ge3), 0);
      chk("t6_diff_lt", 32'(diff3), 156);
      req3 = '0;
      tick(1);
      a3[23:16] = 8'd9; b3[23:16] = 8'd9; req3 = 3'b100;
      tick(2);
      chk("t6_ack2", 32'(ack3), 4);
      req3 = 3'b101;
      tick(3);
      chk("t6_wrap", 32'(ack3), 1);
      chk("t6_wrap_gnt", 32'(gnt3), 0);
      req3 = 3'b100;
      tick(3);
      chk("t6_then2", 32'(ack3), 4);
      req3 = '0;
      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
